// File: rtl/cma_arbiter.sv
// cma_arbiter: round-robin share of one compOp complex mult/add unit between two requesters.
// Operands and op are latched at grant; the result is returned with a one-cycle done pulse.
// Optional abort on a stuck compOp is enabled by defining CMA_TIMEOUT_EN.
module cma_arbiter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req0,
   input  logic             i_req1,
   input  logic             i_op0,
   input  logic             i_op1,
   input  logic [WIDTH-1:0] i_a0_re,
   input  logic [WIDTH-1:0] i_a0_im,
   input  logic [WIDTH-1:0] i_b0_re,
   input  logic [WIDTH-1:0] i_b0_im,
   input  logic [WIDTH-1:0] i_a1_re,
   input  logic [WIDTH-1:0] i_a1_im,
   input  logic [WIDTH-1:0] i_b1_re,
   input  logic [WIDTH-1:0] i_b1_im,
   output logic             o_gnt0,
   output logic             o_gnt1,
   output logic             o_done0,
   output logic             o_done1,
   output logic [WIDTH-1:0] o_res_re,
   output logic [WIDTH-1:0] o_res_im,
   output logic             o_err,
   output logic             o_busy,
   output logic             o_cma_start,
   output logic             o_cma_op,
   output logic [WIDTH-1:0] o_cma_re1,
   output logic [WIDTH-1:0] o_cma_im1,
   output logic [WIDTH-1:0] o_cma_re2,
   output logic [WIDTH-1:0] o_cma_im2,
   input  logic [WIDTH-1:0] i_cma_re,
   input  logic [WIDTH-1:0] i_cma_im,
   input  logic             i_cma_ready
);

   typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

   state_e           r_state, w_state_d;
   logic             r_rr, w_rr_d;
   logic             r_owner, w_owner_d;
   logic             r_gnt0, w_gnt0_d;
   logic             r_gnt1, w_gnt1_d;
   logic             r_done0, w_done0_d;
   logic             r_done1, w_done1_d;
   logic             r_err, w_err_d;
   logic             r_busy, w_busy_d;
   logic             r_cma_start, w_cma_start_d;
   logic             r_cma_op, w_cma_op_d;
   logic [WIDTH-1:0] r_cma_re1, w_cma_re1_d;
   logic [WIDTH-1:0] r_cma_im1, w_cma_im1_d;
   logic [WIDTH-1:0] r_cma_re2, w_cma_re2_d;
   logic [WIDTH-1:0] r_cma_im2, w_cma_im2_d;
   logic [WIDTH-1:0] r_res_re, w_res_re_d;
   logic [WIDTH-1:0] r_res_im, w_res_im_d;
   logic             w_sel1;
   logic             w_timeout;
`ifdef CMA_TIMEOUT_EN
   localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);
   logic [7:0]       r_cnt, w_cnt_d;
`endif

   // Next-state: arbitration at accept, completion/abort in BUSY, one-cycle start-low gap
   always_comb begin
      w_state_d     = r_state;
      w_rr_d        = r_rr;
      w_owner_d     = r_owner;
      w_gnt0_d      = r_gnt0;
      w_gnt1_d      = r_gnt1;
      w_done0_d     = 1'b0;
      w_done1_d     = 1'b0;
      w_err_d       = 1'b0;
      w_cma_start_d = r_cma_start;
      w_cma_op_d    = r_cma_op;
      w_cma_re1_d   = r_cma_re1;
      w_cma_im1_d   = r_cma_im1;
      w_cma_re2_d   = r_cma_re2;
      w_cma_im2_d   = r_cma_im2;
      w_res_re_d    = r_res_re;
      w_res_im_d    = r_res_im;
      w_sel1        = 1'b0;
      w_timeout     = 1'b0;
`ifdef CMA_TIMEOUT_EN
      w_cnt_d       = r_cnt;
`endif
      unique case (r_state)
         StIdle: begin
            if (i_req0 | i_req1) begin
               // Requester 1 wins only when it is alone or the pointer favours it
               w_sel1        = i_req1 & (~i_req0 | r_rr);
               w_owner_d     = w_sel1;
               w_gnt0_d      = ~w_sel1;
               w_gnt1_d      = w_sel1;
               w_cma_op_d    = w_sel1 ? i_op1   : i_op0;
               w_cma_re1_d   = w_sel1 ? i_a1_re : i_a0_re;
               w_cma_im1_d   = w_sel1 ? i_a1_im : i_a0_im;
               w_cma_re2_d   = w_sel1 ? i_b1_re : i_b0_re;
               w_cma_im2_d   = w_sel1 ? i_b1_im : i_b0_im;
               w_cma_start_d = 1'b1;
               w_state_d     = StBusy;
`ifdef CMA_TIMEOUT_EN
               w_cnt_d       = 8'd0;
`endif
            end
         end
         StBusy: begin
`ifdef CMA_TIMEOUT_EN
            w_cnt_d   = r_cnt + 8'd1;
            // A ready in the expiry cycle still completes normally
            w_timeout = (r_cnt == CntLast) & ~i_cma_ready;
`endif
            if (i_cma_ready | w_timeout) begin
               w_res_re_d    = w_timeout ? '0 : i_cma_re;
               w_res_im_d    = w_timeout ? '0 : i_cma_im;
               w_done0_d     = ~r_owner;
               w_done1_d     = r_owner;
               w_err_d       = w_timeout;
               w_cma_start_d = 1'b0;
               w_rr_d        = ~r_owner;
               w_state_d     = StGap;
            end
         end
         StGap: begin
            w_gnt0_d  = 1'b0;
            w_gnt1_d  = 1'b0;
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
      w_busy_d = (w_state_d != StIdle);
   end

   // State and registered outputs, synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_rr        <= 1'b0;
         r_owner     <= 1'b0;
         r_gnt0      <= 1'b0;
         r_gnt1      <= 1'b0;
         r_done0     <= 1'b0;
         r_done1     <= 1'b0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
         r_cma_start <= 1'b0;
         r_cma_op    <= 1'b0;
         r_cma_re1   <= '0;
         r_cma_im1   <= '0;
         r_cma_re2   <= '0;
         r_cma_im2   <= '0;
         r_res_re    <= '0;
         r_res_im    <= '0;
`ifdef CMA_TIMEOUT_EN
         r_cnt       <= 8'd0;
`endif
      end else begin
         r_state     <= w_state_d;
         r_rr        <= w_rr_d;
         r_owner     <= w_owner_d;
         r_gnt0      <= w_gnt0_d;
         r_gnt1      <= w_gnt1_d;
         r_done0     <= w_done0_d;
         r_done1     <= w_done1_d;
         r_err       <= w_err_d;
         r_busy      <= w_busy_d;
         r_cma_start <= w_cma_start_d;
         r_cma_op    <= w_cma_op_d;
         r_cma_re1   <= w_cma_re1_d;
         r_cma_im1   <= w_cma_im1_d;
         r_cma_re2   <= w_cma_re2_d;
         r_cma_im2   <= w_cma_im2_d;
         r_res_re    <= w_res_re_d;
         r_res_im    <= w_res_im_d;
`ifdef CMA_TIMEOUT_EN
         r_cnt       <= w_cnt_d;
`endif
      end
   end

   assign o_gnt0      = r_gnt0;
   assign o_gnt1      = r_gnt1;
   assign o_done0     = r_done0;
   assign o_done1     = r_done1;
   assign o_err       = r_err;
   assign o_busy      = r_busy;
   assign o_cma_start = r_cma_start;
   assign o_cma_op    = r_cma_op;
   assign o_cma_re1   = r_cma_re1;
   assign o_cma_im1   = r_cma_im1;
   assign o_cma_re2   = r_cma_re2;
   assign o_cma_im2   = r_cma_im2;
   assign o_res_re    = r_res_re;
   assign o_res_im    = r_res_im;

endmodule
